ahblite_slave_mux: RTL and testbench

//  AHB-Lite data-phase response multiplexer with an integrated default slave.

---
 rtl/ahblite_slave_mux_if.sv | 20 ++
 rtl/ahblite_slave_mux.sv | 53 +++++
 tb/tb_ahblite_slave_mux.sv | 109 ++++++++++
 3 files changed

// File: rtl/ahblite_slave_mux_if.sv
// ahblite_slave_mux_if: AHB-Lite data-phase response bus between decoder/slaves, master and the mux
interface ahblite_slave_mux_if;
  logic [7:0]   HSEL_A;
  logic [1:0]   HTRANS;
  logic         HREADY;
  logic [255:0] HRDATA_S;
  logic [7:0]   HREADYOUT_S;
  logic [7:0]   HRESP_S;
  logic [31:0]  HRDATA;
  logic         HREADY_OUT;
  logic         HRESP;
  modport slave (
    input  HSEL_A, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY_OUT, HRESP
  );
  modport master (
    output HSEL_A, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY_OUT, HRESP
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux: registers the decoder selection per address phase and muxes slave responses, with a default error slave
module ahblite_slave_mux #(
  parameter int NUM_SLAVES = 5,
  parameter bit ERR_EN     = 1
) (
  input logic          HCLK,
  input logic          HRESET,
  ahblite_slave_mux_if.slave bus
);
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
  ds_state_t state, next_state;
  logic       sel_v;
  logic [2:0] sel_idx;
  logic       hit;
  logic [2:0] idx;
  logic       err_start;
  // descending scan so the lowest set in-range bit wins on multi-hot input
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (bus.HSEL_A[i]) begin
        hit = 1'b1;
        idx = 3'(i);
      end
  end
  assign err_start = ERR_EN && bus.HREADY && bus.HTRANS[1] && !hit;
  always_comb begin
    next_state = DS_IDLE;
    case (state)
      DS_IDLE: next_state = err_start ? DS_ERR1 : DS_IDLE;
      DS_ERR1: next_state = DS_ERR2;
      DS_ERR2: next_state = err_start ? DS_ERR1 : DS_IDLE;
      default: next_state = DS_IDLE;
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= DS_IDLE;
      sel_v   <= 1'b0;
      sel_idx <= 3'd0;
    end else begin
      state <= next_state;
      if (bus.HREADY) begin
        sel_v   <= hit;
        sel_idx <= idx;
      end
    end
  end
  assign bus.HRDATA     = sel_v ? bus.HRDATA_S[{sel_idx, 5'd0} +: 32] : 32'd0;
  assign bus.HREADY_OUT = sel_v ? bus.HREADYOUT_S[sel_idx] : (state != DS_ERR1);
  assign bus.HRESP      = sel_v ? bus.HRESP_S[sel_idx] : (state != DS_IDLE);
endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb_ahblite_slave_mux: table-driven checks of selection, muxing and default-slave ERROR sequencing
module tb_ahblite_slave_mux;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int checks = 0;
  int failures = 0;
  ahblite_slave_mux_if bus ();
  ahblite_slave_mux #(.NUM_SLAVES(5), .ERR_EN(1)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));
  assign bus.HREADY = bus.HREADY_OUT;
  always #5 HCLK = ~HCLK;
  typedef struct packed {
    logic [7:0]  sel;
    logic [1:0]  trans;
    logic [7:0]  rdy;
    logic [7:0]  rsp;
    logic [31:0] data;
    logic        ready;
    logic        resp;
  } vec_t;
  vec_t v [20];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic chk_out(input string name, input logic [31:0] d, input logic r, input logic e);
    chk({name, ".HRDATA"}, bus.HRDATA, d);
    chk({name, ".HREADY_OUT"}, 32'(bus.HREADY_OUT), 32'(r));
    chk({name, ".HRESP"}, 32'(bus.HRESP), 32'(e));
  endtask
  task automatic drive(input logic [7:0] s, input logic [1:0] t, input logic [7:0] r, input logic [7:0] p);
    bus.HSEL_A = s;
    bus.HTRANS = t;
    bus.HREADYOUT_S = r;
    bus.HRESP_S = p;
  endtask
  initial begin
    bus.HRDATA_S = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                    32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h00000A0A};
    drive(8'h00, 2'd0, 8'hFF, 8'h00);
    v[0]  = '{8'h00, 2'd0, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b0};
    v[1]  = '{8'h02, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b0};
    v[2]  = '{8'h00, 2'd0, 8'hFF, 8'h00, 32'hDEADBEEF, 1'b1, 1'b0};
    v[3]  = '{8'h10, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b0};
    v[4]  = '{8'h01, 2'd2, 8'hEF, 8'h00, 32'h44444444, 1'b0, 1'b0};
    v[5]  = '{8'h01, 2'd2, 8'hEF, 8'h00, 32'h44444444, 1'b0, 1'b0};
    v[6]  = '{8'h01, 2'd2, 8'hEF, 8'h00, 32'h44444444, 1'b0, 1'b0};
    v[7]  = '{8'h01, 2'd2, 8'hFF, 8'h00, 32'h44444444, 1'b1, 1'b0};
    v[8]  = '{8'h00, 2'd2, 8'hFF, 8'h00, 32'h00000A0A, 1'b1, 1'b0};
    v[9]  = '{8'h00, 2'd0, 8'hFF, 8'h00, 32'h0,        1'b0, 1'b1};
    v[10] = '{8'h00, 2'd0, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b1};
    v[11] = '{8'h20, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b0};
    v[12] = '{8'h20, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b0, 1'b1};
    v[13] = '{8'h80, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b1};
    v[14] = '{8'h04, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b0, 1'b1};
    v[15] = '{8'h04, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b1};
    v[16] = '{8'h06, 2'd2, 8'hFF, 8'h04, 32'h22222222, 1'b1, 1'b1};
    v[17] = '{8'h00, 2'd0, 8'hFF, 8'h00, 32'hDEADBEEF, 1'b1, 1'b0};
    v[18] = '{8'h08, 2'd2, 8'hFF, 8'h00, 32'h0,        1'b1, 1'b0};
    v[19] = '{8'h00, 2'd0, 8'hFF, 8'h00, 32'h33333333, 1'b1, 1'b0};
    #1;
    chk_out("in_reset", 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      drive(v[i].sel, v[i].trans, v[i].rdy, v[i].rsp);
      #1;
      chk_out($sformatf("vec%0d", i), v[i].data, v[i].ready, v[i].resp);
    end
    // reset mid-ERROR: enter DS_ERR1 then pulse reset between edges
    @(negedge HCLK);
    drive(8'h00, 2'd2, 8'hFF, 8'h00);
    @(negedge HCLK);
    drive(8'h00, 2'd0, 8'hFF, 8'h00);
    #1;
    chk_out("err1_before_rst", 32'h0, 1'b0, 1'b1);
    HRESET = 1'b1;
    #1;
    chk_out("err1_async_rst", 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(8'h02, 2'd2, 8'hFF, 8'h00);
    @(negedge HCLK);
    drive(8'h00, 2'd0, 8'hFF, 8'h00);
    #1;
    chk_out("after_rst_clean", 32'hDEADBEEF, 1'b1, 1'b0);
    // reset mid-wait on slot4
    @(negedge HCLK);
    drive(8'h10, 2'd2, 8'hFF, 8'h00);
    @(negedge HCLK);
    drive(8'h00, 2'd0, 8'hEF, 8'h10);
    #1;
    chk_out("wait_before_rst", 32'h44444444, 1'b0, 1'b1);
    HRESET = 1'b1;
    #1;
    chk_out("wait_async_rst", 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(8'h00, 2'd0, 8'hFF, 8'h00);
    @(negedge HCLK);
    #1;
    chk_out("idle_after_rst", 32'h0, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
